// File: rtl/ddr_cmd_dispatch.sv
// Consumer side of the DDR request FIFOs: pops write/read requests and drives the
// MIG-style app command and write-data channels. Every output comes from a flop.
module ddr_cmd_dispatch #(
  parameter int ADDR_W = 27,
  parameter int APP_DW = 64,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  init_calib_complete,
  input  logic [ADDR_W-1:0]     wr_adx_in,
  input  logic [2*APP_DW-1:0]   wr_data_in,
  input  logic                  has_wr_adx,
  input  logic                  has_wr_data,
  output logic                  get_wr_adx,
  output logic                  get_wr_data,
  input  logic [ADDR_W-1:0]     rd_adx_in,
  input  logic                  has_rd_req,
  output logic                  get_rd_req,
  output logic [ADDR_W-1:0]     app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [APP_DW-1:0]     app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [APP_DW/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_rdy,
  output logic                  busy,
  output logic [CNT_W-1:0]      wr_issued,
  output logic [CNT_W-1:0]      rd_issued
);

  typedef enum logic [2:0] {S_IDLE, S_WD_LO, S_WD_HI, S_WCMD, S_RCMD} state_t;

  state_t              state_q, state_d;
  logic                get_wr_q, get_wr_d;
  logic                get_rd_q, get_rd_d;
  logic                last_wr_q, last_wr_d;
  logic [ADDR_W-1:0]   wadx_q, wadx_d;
  logic [APP_DW-1:0]   wdata_hi_q, wdata_hi_d;
  logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
  logic [2:0]          app_cmd_q, app_cmd_d;
  logic                app_en_q, app_en_d;
  logic [APP_DW-1:0]   wdf_data_q, wdf_data_d;
  logic                wren_q, wren_d;
  logic                wend_q, wend_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                wr_ok, rd_ok, arb;

  // A grant is a registered pop strobe issued while the state is still IDLE;
  // the following edge latches the FIFO head and enters the data/command state.
  always_comb begin
    state_d    = state_q;
    get_wr_d   = 1'b0;
    get_rd_d   = 1'b0;
    last_wr_d  = last_wr_q;
    wadx_d     = wadx_q;
    wdata_hi_d = wdata_hi_q;
    app_addr_d = app_addr_q;
    app_cmd_d  = app_cmd_q;
    app_en_d   = app_en_q;
    wdf_data_d = wdf_data_q;
    wren_d     = wren_q;
    wend_d     = wend_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    arb        = 1'b0;
    wr_ok      = init_calib_complete & has_wr_adx & has_wr_data;
    rd_ok      = init_calib_complete & has_rd_req;

    case (state_q)
      S_IDLE: begin
        if (get_wr_q) begin
          state_d    = S_WD_LO;
          last_wr_d  = 1'b1;
          wadx_d     = wr_adx_in;
          wdata_hi_d = wr_data_in[2*APP_DW-1:APP_DW];
          wdf_data_d = wr_data_in[APP_DW-1:0];
          wren_d     = 1'b1;
        end else if (get_rd_q) begin
          state_d    = S_RCMD;
          last_wr_d  = 1'b0;
          app_addr_d = rd_adx_in;
          app_cmd_d  = 3'b001;
          app_en_d   = 1'b1;
        end else begin
          arb = 1'b1;
        end
      end
      S_WD_LO: begin
        if (app_wdf_rdy) begin
          state_d    = S_WD_HI;
          wdf_data_d = wdata_hi_q;
          wend_d     = 1'b1;
        end
      end
      S_WD_HI: begin
        if (app_wdf_rdy) begin
          state_d    = S_WCMD;
          wren_d     = 1'b0;
          wend_d     = 1'b0;
          app_addr_d = wadx_q;
          app_cmd_d  = 3'b000;
          app_en_d   = 1'b1;
        end
      end
      S_WCMD: begin
        if (app_rdy) begin
          state_d  = S_IDLE;
          app_en_d = 1'b0;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          arb      = 1'b1;
        end
      end
      S_RCMD: begin
        if (app_rdy) begin
          state_d  = S_IDLE;
          app_en_d = 1'b0;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          arb      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strict alternation when both queues are eligible.
    if (arb) begin
      if (wr_ok && (!rd_ok || !last_wr_q)) get_wr_d = 1'b1;
      else if (rd_ok)                      get_rd_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      get_wr_q   <= 1'b0;
      get_rd_q   <= 1'b0;
      last_wr_q  <= 1'b0;
      wadx_q     <= '0;
      wdata_hi_q <= '0;
      app_addr_q <= '0;
      app_cmd_q  <= '0;
      app_en_q   <= 1'b0;
      wdf_data_q <= '0;
      wren_q     <= 1'b0;
      wend_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      get_wr_q   <= get_wr_d;
      get_rd_q   <= get_rd_d;
      last_wr_q  <= last_wr_d;
      wadx_q     <= wadx_d;
      wdata_hi_q <= wdata_hi_d;
      app_addr_q <= app_addr_d;
      app_cmd_q  <= app_cmd_d;
      app_en_q   <= app_en_d;
      wdf_data_q <= wdf_data_d;
      wren_q     <= wren_d;
      wend_q     <= wend_d;
      busy_q     <= busy_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign get_wr_adx   = get_wr_q;
  assign get_wr_data  = get_wr_q;
  assign get_rd_req   = get_rd_q;
  assign app_addr     = app_addr_q;
  assign app_cmd      = app_cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = wdf_data_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wend_q;
  assign app_wdf_mask = '0;
  assign busy         = busy_q;
  assign wr_issued    = wr_cnt_q;
  assign rd_issued    = rd_cnt_q;

endmodule

// File: tb/tb_ddr_cmd_dispatch.sv
// Bench for ddr_cmd_dispatch: FIFO models feed the DUT, a negedge monitor scoreboards
// every accepted beat/command against what was queued when the pop strobe fired.
module tb_ddr_cmd_dispatch;
  localparam int ADDR_W = 27;
  localparam int APP_DW = 64;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic resetn;
  logic init_calib_complete;
  logic [ADDR_W-1:0] wr_adx_in, rd_adx_in;
  logic [2*APP_DW-1:0] wr_data_in;
  logic has_wr_adx, has_wr_data, has_rd_req;
  logic get_wr_adx, get_wr_data, get_rd_req;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy;
  logic [APP_DW-1:0] app_wdf_data;
  logic app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [APP_DW/8-1:0] app_wdf_mask;
  logic busy;
  logic [CNT_W-1:0] wr_issued, rd_issued;

  ddr_cmd_dispatch #(.ADDR_W(ADDR_W), .APP_DW(APP_DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .init_calib_complete(init_calib_complete),
    .wr_adx_in(wr_adx_in), .wr_data_in(wr_data_in), .has_wr_adx(has_wr_adx),
    .has_wr_data(has_wr_data), .get_wr_adx(get_wr_adx), .get_wr_data(get_wr_data),
    .rd_adx_in(rd_adx_in), .has_rd_req(has_rd_req), .get_rd_req(get_rd_req),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .busy(busy),
    .wr_issued(wr_issued), .rd_issued(rd_issued));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [ADDR_W-1:0]   wq_a[$], rq_a[$];
  logic [2*APP_DW-1:0] wq_d[$];
  logic [APP_DW:0]     exp_beat[$];
  logic [ADDR_W+2:0]   exp_cmd[$];
  bit grant_log[$];
  bit pend_wr = 0, pend_rd = 0;
  int cyc = 0, t_wg = 0, t_rg = 0, lat_w = -1, lat_r = -1;
  int n_gw = 0, n_gr = 0, n_beats = 0, n_cmds = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic refresh();
    has_wr_adx  = (wq_a.size() != 0);
    has_wr_data = (wq_d.size() != 0);
    has_rd_req  = (rq_a.size() != 0);
    wr_adx_in   = has_wr_adx  ? wq_a[0] : '0;
    wr_data_in  = has_wr_data ? wq_d[0] : '0;
    rd_adx_in   = has_rd_req  ? rq_a[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // FIFO model: pops land just after the edge that ends the strobe cycle.
  initial forever begin
    @(posedge clk); #1;
    if (pend_wr) begin
      if (wq_a.size() != 0) void'(wq_a.pop_front());
      if (wq_d.size() != 0) void'(wq_d.pop_front());
      pend_wr = 0;
    end
    if (pend_rd) begin
      if (rq_a.size() != 0) void'(rq_a.pop_front());
      pend_rd = 0;
    end
    refresh();
  end

  // Scoreboard monitor, sampling mid-cycle.
  bit p_cstall = 0, p_wstall = 0;
  logic [ADDR_W+2:0] p_cmd;
  logic [APP_DW:0]   p_beat;
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      p_cstall = 0; p_wstall = 0;
    end else begin
      cyc++;
      if (get_wr_adx || get_wr_data) begin
        check("pop_pair", {get_wr_adx, get_wr_data, get_rd_req}, 3'b110);
        if (wq_a.size() == 0 || wq_d.size() == 0) check("pop_wr_nonempty", 0, 1);
        else begin
          exp_beat.push_back({1'b0, wq_d[0][APP_DW-1:0]});
          exp_beat.push_back({1'b1, wq_d[0][2*APP_DW-1:APP_DW]});
          exp_cmd.push_back({3'b000, wq_a[0]});
        end
        grant_log.push_back(1'b1); t_wg = cyc; pend_wr = 1; n_gw++;
      end
      if (get_rd_req) begin
        if (rq_a.size() == 0) check("pop_rd_nonempty", 0, 1);
        else exp_cmd.push_back({3'b001, rq_a[0]});
        grant_log.push_back(1'b0); t_rg = cyc; pend_rd = 1; n_gr++;
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        n_beats++;
        check("wdf_mask", app_wdf_mask, 0);
        if (exp_beat.size() == 0) check("beat_unexpected", {app_wdf_end, app_wdf_data}, 0);
        else check("beat", {app_wdf_end, app_wdf_data}, exp_beat.pop_front());
      end
      if (app_en && app_rdy) begin
        n_cmds++;
        if (app_cmd == 3'b000) lat_w = cyc - t_wg; else lat_r = cyc - t_rg;
        if (exp_cmd.size() == 0) check("cmd_unexpected", {app_cmd, app_addr}, 0);
        else check("cmd", {app_cmd, app_addr}, exp_cmd.pop_front());
      end
      if (p_cstall) check("cmd_hold", {app_en, app_cmd, app_addr}, {1'b1, p_cmd});
      if (p_wstall) check("beat_hold", {app_wdf_wren, app_wdf_end, app_wdf_data}, {1'b1, p_beat});
      p_cstall = app_en && !app_rdy;
      p_wstall = app_wdf_wren && !app_wdf_rdy;
      p_cmd    = {app_cmd, app_addr};
      p_beat   = {app_wdf_end, app_wdf_data};
    end
  end

  typedef struct {
    bit         calib;
    int         n_wa, n_wd, n_rd, cycles, exp_w, exp_r;
    logic [7:0] order;   // bit i = 1 if i-th grant is a write
  } vec_t;
  vec_t vecs[6];

  function automatic logic [140:0] all_outs();
    return {get_wr_adx, get_wr_data, get_rd_req, app_addr, app_cmd, app_en, app_wdf_data,
            app_wdf_wren, app_wdf_end, app_wdf_mask, busy, wr_issued, rd_issued};
  endfunction

  initial begin
    int gw0, gr0, b0, c0, k, wtot, rtot;
    vecs[0] = '{1'b0, 1, 1, 1, 20, 0, 0, 8'h00};
    vecs[1] = '{1'b1, 1, 0, 1, 20, 0, 1, 8'h00};
    vecs[2] = '{1'b1, 0, 1, 0, 20, 0, 0, 8'h00};
    vecs[3] = '{1'b1, 3, 3, 3, 40, 3, 3, 8'h15};
    vecs[4] = '{1'b1, 1, 1, 0, 20, 1, 0, 8'h01};
    vecs[5] = '{1'b1, 1, 1, 1, 20, 1, 1, 8'h02};
    wtot = 0; rtot = 0;

    resetn = 1'b0; init_calib_complete = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    refresh();
    repeat (3) tick();
    check("reset_outputs", all_outs(), 0);
    resetn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      gw0 = n_gw; gr0 = n_gr;
      grant_log.delete();
      init_calib_complete = vecs[v].calib;
      for (int i = 0; i < vecs[v].n_wa; i++) wq_a.push_back(ADDR_W'(v * 256 + i * 8 + 8));
      for (int i = 0; i < vecs[v].n_wd; i++) wq_d.push_back({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < vecs[v].n_rd; i++) rq_a.push_back(ADDR_W'(v * 256 + i * 8 + 128));
      refresh();
      repeat (vecs[v].cycles) tick();
      wtot += vecs[v].exp_w; rtot += vecs[v].exp_r;
      check($sformatf("v%0d_wr_grants", v), n_gw - gw0, vecs[v].exp_w);
      check($sformatf("v%0d_rd_grants", v), n_gr - gr0, vecs[v].exp_r);
      for (int i = 0; i < grant_log.size() && i < 8; i++)
        check($sformatf("v%0d_order%0d", v, i), grant_log[i], vecs[v].order[i]);
      check($sformatf("v%0d_wr_issued", v), wr_issued, wtot);
      check($sformatf("v%0d_rd_issued", v), rd_issued, rtot);
      check($sformatf("v%0d_idle", v), {busy, app_en, app_wdf_wren}, 0);
      if (v == 1) check("rd_latency", lat_r, 1);
      if (v == 4) check("wr_latency", lat_w, 3);
      wq_a.delete(); wq_d.delete(); rq_a.delete();
      refresh();
      tick();
    end

    // Single write with known data, readies high.
    lat_w = -1;
    wq_a.push_back(27'h0000100);
    wq_d.push_back({64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
    refresh();
    repeat (10) tick();
    check("single_wr_latency", lat_w, 3);
    check("single_wr_issued", wr_issued, wtot + 1);
    check("single_wr_addr", {app_cmd, app_addr}, {3'b000, 27'h0000100});

    // Backpressure on both channels.
    b0 = n_beats; c0 = n_cmds;
    app_wdf_rdy = 1'b0; app_rdy = 1'b0;
    wq_a.push_back(27'h0000A40);
    wq_d.push_back({$urandom, $urandom, $urandom, $urandom});
    refresh();
    k = 0;
    while (!app_wdf_wren && k < 10) begin tick(); k++; end
    check("bp_wren_seen", app_wdf_wren, 1);
    repeat (5) tick();
    check("bp_still_lo", {app_wdf_wren, app_wdf_end}, 2'b10);
    app_wdf_rdy = 1'b1;
    k = 0;
    while (!app_en && k < 10) begin tick(); k++; end
    check("bp_en_seen", app_en, 1);
    repeat (4) tick();
    check("bp_still_cmd", {app_en, wr_issued}, {1'b1, 16'(wtot + 1)});
    app_rdy = 1'b1;
    repeat (4) tick();
    check("bp_beats", n_beats - b0, 2);
    check("bp_cmds", n_cmds - c0, 1);
    check("bp_wr_issued", wr_issued, wtot + 2);

    // Reset while the high beat is waiting.
    app_wdf_rdy = 1'b0;
    wq_a.push_back(27'h0000C00);
    wq_d.push_back({$urandom, $urandom, $urandom, $urandom});
    refresh();
    k = 0;
    while (!app_wdf_wren && k < 10) begin tick(); k++; end
    check("rst_wren_seen", app_wdf_wren, 1);
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    check("rst_in_wd_hi", {app_wdf_wren, app_wdf_end, busy}, 3'b111);
    resetn = 1'b0;
    #1;
    check("rst_async_outputs", all_outs(), 0);
    exp_beat.delete(); exp_cmd.delete(); grant_log.delete();
    pend_wr = 0; pend_rd = 0;
    tick();
    check("rst_held_outputs", all_outs(), 0);
    resetn = 1'b1; app_wdf_rdy = 1'b1; app_rdy = 1'b1;
    b0 = n_beats; c0 = n_cmds;
    wq_a.push_back(27'h0000D00);
    wq_d.push_back({64'hAAAA_0000_BBBB_1111, 64'h5555_6666_7777_8888});
    refresh();
    repeat (10) tick();
    check("rst_restart_beats", n_beats - b0, 2);
    check("rst_restart_cmds", n_cmds - c0, 1);
    check("rst_wr_issued", wr_issued, 1);
    check("rst_rd_issued", rd_issued, 0);
    check("sb_drained", exp_beat.size() + exp_cmd.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_dispatch.md
Name: ddr_cmd_dispatch

Overview:
- Consumer end of the DDR request FIFO interface.
- Pops queued write address/data and read addresses, and drives the MIG-style user app command and write-data channels.
- One 128-bit write word is issued as two 64-bit app beats (low half first), followed by the write command.
- Read return data bypasses this block; the app delivers it straight to the request FIFO.

Parameters:
ADDR_W, 27, app/FIFO address width
APP_DW, 64, app write-data beat width; FIFO word is 2*APP_DW
CNT_W, 16, width of issued-command counters

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
init_calib_complete  in  1  DDR calibration done; no dispatch while low
wr_adx_in  in  ADDR_W  head write address from FIFO (show-ahead)
wr_data_in  in  2*APP_DW  head write data from FIFO (show-ahead)
has_wr_adx  in  1  write address FIFO non-empty
has_wr_data  in  1  write data FIFO non-empty
get_wr_adx  out  1  one-cycle pop strobe, write address
get_wr_data  out  1  one-cycle pop strobe, write data
rd_adx_in  in  ADDR_W  head read address from FIFO (show-ahead)
has_rd_req  in  1  read request FIFO non-empty
get_rd_req  out  1  one-cycle pop strobe, read request
app_addr  out  ADDR_W  app command address
app_cmd  out  3  000 write, 001 read
app_en  out  1  app command valid
app_rdy  in  1  app command accepted when app_en and app_rdy both high
app_wdf_data  out  APP_DW  app write beat
app_wdf_wren  out  1  app write beat valid
app_wdf_end  out  1  last beat of burst
app_wdf_mask  out  APP_DW/8  byte mask; constant 0
app_wdf_rdy  in  1  beat accepted when app_wdf_wren and app_wdf_rdy both high
busy  out  1  FSM not in IDLE
wr_issued  out  CNT_W  count of accepted write commands, wraps
rd_issued  out  CNT_W  count of accepted read commands, wraps

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. last_was_wr=0. Latched address/data registers are 0. Reset asserted mid-operation abandons the transaction with no pop and no counter update.
- All outputs are registered.
- States: IDLE, WD_LO, WD_HI, WCMD, RCMD.
- IDLE eligibility:
  - wr_ok = init_calib_complete & has_wr_adx & has_wr_data
  - rd_ok = init_calib_complete & has_rd_req
- IDLE arbitration:
  - Only one eligible: grant it.
  - Both eligible: grant read if last_was_wr=1, else grant write (strict alternation).
  - Neither eligible: stay in IDLE.
- Write grant at cycle N:
  - get_wr_adx and get_wr_data are high during cycle N only.
  - wr_adx_in and wr_data_in are captured at the end of cycle N; last_was_wr is set to 1.
  - Next state is WD_LO, with app_wdf_wren=1 and app_wdf_data=data[APP_DW-1:0] from cycle N+1.
- WD_LO: hold outputs until app_wdf_rdy is sampled high. Then move to WD_HI: data[2*APP_DW-1:APP_DW], app_wdf_wren=1, app_wdf_end=1.
- WD_HI: hold until app_wdf_rdy. Then move to WCMD: app_wdf_wren=0, app_wdf_end=0, app_en=1, app_cmd=000, app_addr=latched address.
- WCMD: hold until app_rdy. Then wr_issued increments, app_en drops and the FSM returns to IDLE. IDLE may grant again on that same return cycle.
- Read grant at cycle N:
  - get_rd_req is high during cycle N only.
  - rd_adx_in is captured; last_was_wr is set to 0.
  - Next state is RCMD with app_en=1, app_cmd=001 from cycle N+1.
- RCMD: hold until app_rdy. Then rd_issued increments and the FSM returns to IDLE.
- Minimum latencies, grant to command acceptance: write 3 cycles, read 1 cycle.
- Stability: app_addr, app_cmd and app_wdf_data are stable whenever their valid is high and ready is low.
- At most one pop strobe group per cycle. A read grant and a write grant never occur in the same cycle.
- A write is not started with only address or only data present; both FIFOs must be non-empty.
- If init_calib_complete drops mid-transaction, the transaction still completes; only new grants are blocked.
- Counters wrap from 2^CNT_W-1 to 0 without a flag.
- busy = (state != IDLE).

Test Plan:
1. Calib low, has_wr_adx=has_wr_data=has_rd_req=1 for 20 cycles -> no get_* strobes, app_en=0, busy=0.
2. Single write: adx 0x0000100, data 0x1111...2222 (hi...lo), app_rdy and app_wdf_rdy held 1 -> beats 0x2222.., then 0x1111.. with end=1, then cmd 000 at addr 0x0000100; wr_issued=1; grant to command acceptance is 3 cycles.
3. Backpressure: app_wdf_rdy low for 5 cycles in WD_LO, app_rdy low for 4 cycles in WCMD -> outputs held stable, exactly one beat pair and one command accepted.
4. Both queues hold 3 entries each, all readies 1 -> grant order W,R,W,R,W,R; rd_issued=wr_issued=3; get strobes total 3 each.
5. has_wr_adx=1 with has_wr_data=0, plus a read pending -> only the read is dispatched, no get_wr_* strobes.
6. resetn pulsed low while in WD_HI -> all outputs are 0 asynchronously, state is IDLE, counters are 0, and the next write restarts from the low beat.
